// File: rtl/hmac_trailer_verify_if.sv
// AXI4-Stream bundle used for the RX input, the stripped-payload output and
// the feed into the external hmac core: 512-bit data, 64-bit keep, 6-bit id.
interface hmac_trailer_verify_if;
    logic         tvalid;
    logic         tready;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic [5:0]   tid;
    logic         tlast;

    // The side that produces the beats.
    modport master (output tvalid, tdata, tkeep, tid, tlast, input tready);
    // The side that consumes the beats.
    modport slave  (input tvalid, tdata, tkeep, tid, tlast, output tready);
endinterface

// File: rtl/hmac_trailer_verify.sv
// hmac_trailer_verify
// Receive-side HMAC trailer checker. A packet is [header | payload... | digest].
// Header and payload go to the hmac core, the payload alone goes downstream,
// header and digest beat are stripped. The core's digest is compared with the
// received trailer and the header IDs and sequence counter are checked; one
// status pulse is produced per packet.
// Optional build macro: HMAC_VERIFY_STATS_EN enables the saturating
// cnt_ok/cnt_bad packet counters (otherwise they are constant zero).
module hmac_trailer_verify #(
    parameter logic [63:0] FPGA_ID               = 64'hC0FFEE0123456789,
    parameter logic [63:0] CONNECTION_ID         = 64'hDEADBEEF98765432,
    parameter logic [63:0] INITIAL_COUNTER_VALUE = 64'd0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    hmac_trailer_verify_if.slave         s_axis,
    hmac_trailer_verify_if.master        m_axis,
    hmac_trailer_verify_if.master        hmac_in,
    input  logic                         hmac_out_tvalid,
    output logic                         hmac_out_tready,
    input  logic [255:0]                 hmac_out_tdata,
    output logic                         stat_valid,
    output logic                         stat_ok,
    output logic                         stat_id_err,
    output logic                         stat_cnt_err,
    output logic                         stat_mac_err,
    output logic [5:0]                   stat_tid,
    output logic [31:0]                  cnt_ok,
    output logic [31:0]                  cnt_bad
);

    typedef enum logic [2:0] {
        S_HDR,
        S_BODY,
        S_FLUSH,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t state_q, state_d;

    // Hold register: the most recent beat, kept back until we know whether it
    // is the final payload beat (the next beat decides its tlast).
    logic         pend_valid_q;
    logic         pend_to_m_q;     // 0 for the header, which never goes downstream
    logic [511:0] pend_data_q;
    logic [63:0]  pend_keep_q;
    logic [5:0]   pend_id_q;

    // Output fork stage: one beat presented to m_axis and hmac_in at once.
    logic         out_valid_q;
    logic         out_to_m_q;
    logic         out_last_q;
    logic         m_done_q;        // m_axis side already handshaked
    logic         h_done_q;        // hmac_in side already handshaked
    logic [511:0] out_data_q;
    logic [63:0]  out_keep_q;
    logic [5:0]   out_id_q;

    // Per-packet verification context.
    logic [255:0] digest_q;
    logic [63:0]  rx_cnt_q;
    logic [63:0]  exp_cnt_q;
    logic [5:0]   tid_q;
    logic         id_err_q;
    logic         cnt_err_q;
    logic         mac_ok_q;
    logic         payload_q;       // at least one payload beat seen

    // FSM strobes.
    logic s_ready;
    logic core_ready;
    logic hdr_take;
    logic hdr_direct;
    logic pend_load;
    logic move_pend;
    logic move_last;
    logic digest_take;
    logic report;

    // Handshake and fork bookkeeping.
    logic s_hs;
    logic m_hs;
    logic h_hs;
    logic m_side_done;
    logic h_side_done;
    logic out_free;
    logic mac_err;
    logic pkt_ok;

    assign s_hs = s_axis.tvalid & s_ready;
    assign m_hs = m_axis.tvalid & m_axis.tready;
    assign h_hs = hmac_in.tvalid & hmac_in.tready;

    // A side is finished when it does not need the beat, already took it,
    // or takes it this cycle. The stage frees only when both sides are finished.
    assign m_side_done = ~out_to_m_q | m_done_q | m_hs;
    assign h_side_done = h_done_q | h_hs;
    assign out_free    = ~out_valid_q | (m_side_done & h_side_done);

    // Next-state and strobe decode for the packet FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_d     = state_q;
        s_ready     = 1'b0;
        core_ready  = 1'b0;
        hdr_take    = 1'b0;
        hdr_direct  = 1'b0;
        pend_load   = 1'b0;
        move_pend   = 1'b0;
        move_last   = 1'b0;
        digest_take = 1'b0;
        report      = 1'b0;
        unique case (state_q)
            S_HDR: begin
                s_ready = ~pend_valid_q & ~out_valid_q;
                if (s_axis.tvalid && s_ready) begin
                    hdr_take = 1'b1;
                    if (s_axis.tlast) begin
                        // Header-only packet: header goes straight out as the last beat.
                        hdr_direct = 1'b1;
                        state_d    = S_FLUSH;
                    end else begin
                        pend_load = 1'b1;
                        state_d   = S_BODY;
                    end
                end
            end
            S_BODY: begin
                s_ready = ~pend_valid_q | out_free;
                if (s_axis.tvalid && s_ready) begin
                    move_pend = pend_valid_q;
                    if (s_axis.tlast) begin
                        // Digest beat: consumed here, the held beat closes the packet.
                        digest_take = 1'b1;
                        move_last   = 1'b1;
                        state_d     = S_FLUSH;
                    end else begin
                        pend_load = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!pend_valid_q && out_free) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                core_ready = 1'b1;
                if (hmac_out_tvalid) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                report  = 1'b1;
                state_d = S_HDR;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold-register and fork-stage control flags.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pend_valid_q <= 1'b0;
            pend_to_m_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_to_m_q   <= 1'b0;
            out_last_q   <= 1'b0;
            m_done_q     <= 1'b0;
            h_done_q     <= 1'b0;
        end else begin
            if (pend_load) begin
                pend_valid_q <= 1'b1;
                pend_to_m_q  <= (state_q == S_BODY);
            end else if (move_pend) begin
                pend_valid_q <= 1'b0;
            end

            if (hdr_direct || move_pend) begin
                // Only reached when out_free, so the previous beat is fully delivered.
                out_valid_q <= 1'b1;
                out_to_m_q  <= hdr_direct ? 1'b0 : pend_to_m_q;
                out_last_q  <= hdr_direct ? 1'b1 : move_last;
                m_done_q    <= 1'b0;
                h_done_q    <= 1'b0;
            end else if (out_valid_q) begin
                if (m_side_done && h_side_done) begin
                    out_valid_q <= 1'b0;
                    m_done_q    <= 1'b0;
                    h_done_q    <= 1'b0;
                end else begin
                    if (m_hs) m_done_q <= 1'b1;
                    if (h_hs) h_done_q <= 1'b1;
                end
            end
        end
    end

    // Beat payload storage for the hold register and the fork stage.
    // NOTE: these wide registers are not reset; the valid flags above decide whether they mean anything.
    always_ff @(posedge aclk) begin
        if (pend_load) begin
            pend_data_q <= s_axis.tdata;
            pend_keep_q <= s_axis.tkeep;
            pend_id_q   <= s_axis.tid;
        end
        if (hdr_direct) begin
            out_data_q <= s_axis.tdata;
            out_keep_q <= s_axis.tkeep;
            out_id_q   <= s_axis.tid;
        end else if (move_pend) begin
            out_data_q <= pend_data_q;
            out_keep_q <= pend_keep_q;
            out_id_q   <= pend_id_q;
        end
    end

    // Header checks, digest capture, digest compare and counter resync.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            digest_q  <= '0;
            rx_cnt_q  <= '0;
            exp_cnt_q <= INITIAL_COUNTER_VALUE;
            tid_q     <= '0;
            id_err_q  <= 1'b0;
            cnt_err_q <= 1'b0;
            mac_ok_q  <= 1'b0;
            payload_q <= 1'b0;
        end else begin
            if (hdr_take) begin
                id_err_q  <= (s_axis.tdata[63:0]   != FPGA_ID) ||
                             (s_axis.tdata[127:64] != CONNECTION_ID);
                cnt_err_q <= (s_axis.tdata[191:128] != exp_cnt_q);
                rx_cnt_q  <= s_axis.tdata[191:128];
                tid_q     <= s_axis.tid;
                payload_q <= 1'b0;
                mac_ok_q  <= 1'b0;
                // Header-only packets have no trailer; compare against zero.
                digest_q  <= '0;
            end
            if (pend_load && (state_q == S_BODY)) begin
                payload_q <= 1'b1;
            end
            if (digest_take) begin
                digest_q <= s_axis.tdata[255:0];
            end
            if (core_ready && hmac_out_tvalid) begin
                mac_ok_q <= (hmac_out_tdata == digest_q);
            end
            if (report) begin
                // Follow the sender's counter even after a mismatch.
                exp_cnt_q <= rx_cnt_q + 64'd1;
            end
        end
    end

    assign s_axis.tready   = aresetn & s_ready;
    assign hmac_out_tready = aresetn & core_ready;

    assign m_axis.tvalid  = out_valid_q & out_to_m_q & ~m_done_q;
    assign m_axis.tdata   = out_data_q;
    assign m_axis.tkeep   = out_keep_q;
    assign m_axis.tid     = out_id_q;
    assign m_axis.tlast   = out_last_q;

    assign hmac_in.tvalid = out_valid_q & ~h_done_q;
    assign hmac_in.tdata  = out_data_q;
    assign hmac_in.tkeep  = out_keep_q;
    assign hmac_in.tid    = out_id_q;
    assign hmac_in.tlast  = out_last_q;

    // A packet without payload can never authenticate.
    assign mac_err = ~mac_ok_q | ~payload_q;
    assign pkt_ok  = ~(id_err_q | cnt_err_q | mac_err);

    assign stat_valid   = (state_q == S_REPORT);
    assign stat_ok      = stat_valid & pkt_ok;
    assign stat_id_err  = stat_valid & id_err_q;
    assign stat_cnt_err = stat_valid & cnt_err_q;
    assign stat_mac_err = stat_valid & mac_err;
    assign stat_tid     = tid_q;

`ifdef HMAC_VERIFY_STATS_EN
    logic [31:0] cnt_ok_q;
    logic [31:0] cnt_bad_q;

    // Saturating good/bad packet counters, stepped once per status pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_ok_q  <= '0;
            cnt_bad_q <= '0;
        end else if (report) begin
            if (pkt_ok) begin
                if (cnt_ok_q != 32'hFFFF_FFFF) cnt_ok_q <= cnt_ok_q + 32'd1;
            end else begin
                if (cnt_bad_q != 32'hFFFF_FFFF) cnt_bad_q <= cnt_bad_q + 32'd1;
            end
        end
    end

    assign cnt_ok  = cnt_ok_q;
    assign cnt_bad = cnt_bad_q;
`else
    assign cnt_ok  = '0;
    assign cnt_bad = '0;
`endif

endmodule
